// File: rtl/adder_seq_nb.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock, valid/ready in and out.
// Latency WIDTH/CHUNK cycles from acceptance to out_valid; result held in DONE until out_ready.
// Optional status flags are built only when ADDER_SEQ_FLAGS_EN is defined.
module adder_seq_nb #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [2:0]       flags
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("adder_seq_nb: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   beff_q, beff_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CHUNK:0]     chunk_res;
  logic               last_chunk;
  int                 lo;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    beff_d     = beff_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    lo         = int'(idx_q) * CHUNK;
    last_chunk = (idx_q == IDX_W'(N - 1));
    chunk_res  = {1'b0, a_q[lo +: CHUNK]} + {1'b0, beff_q[lo +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          beff_d  = sub ? ~b : b;
          // Subtraction runs as a + ~b + 1, so the borrow-in enters inverted.
          carry_d = sub ^ carry_in;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[lo +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d            = chunk_res[CHUNK];
        idx_d              = idx_q + 1'b1;
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ADDER_SEQ_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  // Flags are taken from the fully assembled sum on the final chunk edge.
  always_comb begin
    flags_d = flags_q;
    if (state_q == RUN && last_chunk) begin
      flags_d = {(a_q[WIDTH-1] == beff_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]),
                 sum_d[WIDTH-1],
                 ~|sum_d};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_adder_seq_nb.sv
// Bench for adder_seq_nb: 8/4, 16/4 and 16/16 instances checked against a queue-based scoreboard.
module tb_adder_seq_nb;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic [2:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [2:0] flags8;

  logic        in_valid16, cin16, sub16, out_ready16;
  logic [15:0] a16, b16;
  logic        in_ready16a, out_valid16a, cout16a, in_ready16b, out_valid16b, cout16b;
  logic [15:0] sum16a, sum16b;
  logic [2:0]  flags16a, flags16b;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t q8[$];
  exp_t q16[$];

  adder_seq_nb #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .carry_in(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(cout8), .flags(flags8));

  adder_seq_nb #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16a),
    .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
    .out_valid(out_valid16a), .out_ready(out_ready16),
    .sum(sum16a), .carry_out(cout16a), .flags(flags16a));

  adder_seq_nb #(.WIDTH(16), .CHUNK(16)) dut16w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16b),
    .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
    .out_valid(out_valid16b), .out_ready(out_ready16),
    .sum(sum16b), .carry_out(cout16b), .flags(flags16b));

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] mask, beff, full;
    exp_t r;
    mask    = (32'd1 << w) - 32'd1;
    beff    = (sub ? ~{16'h0, b} : {16'h0, b}) & mask;
    full    = {16'h0, a} + beff + {31'd0, sub ^ cin};
    r.sum   = full[15:0] & mask[15:0];
    r.cout  = full[w];
    r.flags = 3'b000;
`ifdef ADDER_SEQ_FLAGS_EN
    r.flags = {(a[w-1] == beff[w-1]) && (r.sum[w-1] != a[w-1]), r.sum[w-1], r.sum == 16'h0};
`endif
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge with operands scrambled.
  task automatic accept8(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
    int t = 0;
    a8 = av; b8 = bv; cin8 = c; sub8 = s; in_valid8 = 1'b1;
    while (!in_ready8 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    n_cmp++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    n_cmp++; if (flags8 !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags8); end
    n_cmp++; if ({in_ready16a, in_ready16b, out_valid16a, out_valid16b} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_wide_hs got=%b exp=1100", {in_ready16a, in_ready16b, out_valid16a, out_valid16b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] va[8] = '{8'h3C, 8'hFF, 8'h10, 8'h7F, 8'h00, 8'h80, 8'h55, 8'h01};
    logic [7:0] vb[8] = '{8'h15, 8'h01, 8'h20, 8'h01, 8'h00, 8'h01, 8'h55, 8'h01};
    logic       vc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       vs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] av, bv;
      logic c, s;
      if (i < 8) begin av = va[i]; bv = vb[i]; c = vc[i]; s = vs[i]; end
      else begin av = 8'($urandom); bv = 8'($urandom); c = 1'($urandom); s = 1'($urandom); end
      accept8(av, bv, c, s);
      q8.push_back(model(8, {8'h0, av}, {8'h0, bv}, c, s));
      wait_out8(lat);
      e = q8.pop_front();
      n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL add%0d_latency got=%0d exp=2", i, lat); end
      n_cmp++; if (sum8 !== e.sum[7:0]) begin n_fail++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum8, e.sum[7:0]); end
      n_cmp++; if (cout8 !== e.cout) begin n_fail++; $display("FAIL add%0d_cout got=%b exp=%b", i, cout8, e.cout); end
      n_cmp++; if (flags8 !== e.flags) begin n_fail++; $display("FAIL add%0d_flags got=%b exp=%b", i, flags8, e.flags); end
      release8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    accept8(8'h5A, 8'h33, 1'b1, 1'b0);
    q8.push_back(model(8, 16'h005A, 16'h0033, 1'b1, 1'b0));
    wait_out8(lat);
    e = q8.pop_front();
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d_hs got=%b%b exp=10", k, out_valid8, in_ready8);
      end
      n_cmp++; if (sum8 !== e.sum[7:0] || cout8 !== e.cout) begin
        n_fail++; $display("FAIL bp_hold%0d_result got=%h/%b exp=%h/%b", k, sum8, cout8, e.sum[7:0], e.cout);
      end
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL bp_after_xfer got=%b%b exp=10", in_ready8, out_valid8);
    end
    q8.push_back(model(8, 16'h0001, 16'h0002, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got=%b exp=0", in_ready8); end
    wait_out8(lat);
    e = q8.pop_front();
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bp_next_latency got=%0d exp=2", lat); end
    n_cmp++; if (sum8 !== e.sum[7:0]) begin n_fail++; $display("FAIL bp_next_sum got=%h exp=%h", sum8, e.sum[7:0]); end
    release8();
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    accept8(8'hAA, 8'h55, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hs got=%b%b exp=10", in_ready8, out_valid8);
    end
    n_cmp++; if (sum8 !== 8'h00 || cout8 !== 1'b0 || flags8 !== 3'b000) begin
      n_fail++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/000", sum8, cout8, flags8);
    end
    for (int k = 0; k < 10; k++) begin
      if (out_valid8) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
  endtask

  task automatic test_wide();
    logic [15:0] va, vb;
    logic c, s;
    int lat_a, lat_b;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin va = 16'h0FFF; vb = 16'h0001; c = 1'b0; s = 1'b0; end
      else begin va = 16'($urandom); vb = 16'($urandom); c = 1'($urandom); s = 1'($urandom); end
      a16 = va; b16 = vb; cin16 = c; sub16 = s; in_valid16 = 1'b1;
      n_cmp++; if (in_ready16a !== 1'b1 || in_ready16b !== 1'b1) begin
        n_fail++; $display("FAIL wide%0d_ready got=%b%b exp=11", i, in_ready16a, in_ready16b);
      end
      @(posedge clk);
      q16.push_back(model(16, va, vb, c, s));
      @(negedge clk);
      in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      lat_a = -1; lat_b = -1;
      for (int k = 0; k < 20 && (lat_a < 0 || lat_b < 0); k++) begin
        if (lat_a < 0 && out_valid16a) lat_a = k;
        if (lat_b < 0 && out_valid16b) lat_b = k;
        @(negedge clk);
      end
      e = q16.pop_front();
      n_cmp++; if (lat_a != 4) begin n_fail++; $display("FAIL wide%0d_lat_c4 got=%0d exp=4", i, lat_a); end
      n_cmp++; if (lat_b != 1) begin n_fail++; $display("FAIL wide%0d_lat_c16 got=%0d exp=1", i, lat_b); end
      n_cmp++; if (sum16a !== e.sum || cout16a !== e.cout || flags16a !== e.flags) begin
        n_fail++; $display("FAIL wide%0d_res_c4 got=%h/%b/%b exp=%h/%b/%b", i, sum16a, cout16a, flags16a, e.sum, e.cout, e.flags);
      end
      n_cmp++; if (sum16b !== e.sum || cout16b !== e.cout || flags16b !== e.flags) begin
        n_fail++; $display("FAIL wide%0d_res_c16 got=%h/%b/%b exp=%h/%b/%b", i, sum16b, cout16b, flags16b, e.sum, e.cout, e.flags);
      end
      out_ready16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready16 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
